// File: rtl/fetch_pc_if.sv
// Fetch-stage signal bundle: next-PC/stall from the pipeline, instruction memory
// handshake, and the PC/instruction/status outputs of the fetch unit.
interface fetch_pc_if #(
   parameter int unsigned bit_size    = 18,
   parameter int unsigned instr_width = 32
);
   logic [bit_size-1:0]    next_pc;
   logic                   stall;
   logic                   im_ack;
   logic [instr_width-1:0] im_rdata;
   logic                   im_req;
   logic [bit_size-1:0]    im_addr;
   logic [bit_size-1:0]    pc;
   logic [bit_size-1:0]    pc_plus4;
   logic [instr_width-1:0] instr;
   logic                   instr_valid;
   logic [31:0]            retire_cnt;
   logic                   addr_err;

   modport slave (
      input  next_pc, stall, im_ack, im_rdata,
      output im_req, im_addr, pc, pc_plus4, instr, instr_valid, retire_cnt, addr_err
   );

   modport master (
      output next_pc, stall, im_ack, im_rdata,
      input  im_req, im_addr, pc, pc_plus4, instr, instr_valid, retire_cnt, addr_err
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: fetches the word at pc over a
// req/ack handshake, holds it while executing, and retires into next_pc.
module fetch_pc_unit #(
   parameter int unsigned          bit_size    = 18,
   parameter int unsigned          instr_width = 32,
   parameter logic [bit_size-1:0]  reset_pc    = '0
) (
   input  logic        clk,
   input  logic        rst,
   fetch_pc_if.slave   bus
);

   localparam int unsigned CntW = 32;
   // Low two bits are forced to zero so a misconfigured reset_pc still fetches aligned.
   localparam logic [bit_size-1:0] ResetPcAligned = {reset_pc[bit_size-1:2], 2'b00};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [bit_size-1:0]    pc_q, pc_d;
   logic [instr_width-1:0] instr_q, instr_d;
   logic [CntW-1:0]        retire_cnt_q, retire_cnt_d;
   logic                   addr_err_q, addr_err_d;

   // State and architectural registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= ResetPcAligned;
         instr_q      <= '0;
         retire_cnt_q <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         retire_cnt_q <= retire_cnt_d;
         addr_err_q   <= addr_err_d;
      end
   end

   // Next-state: capture on ack in FETCH, retire on !stall in EXEC
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      retire_cnt_d = retire_cnt_q;
      addr_err_d   = addr_err_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.im_ack) begin
               instr_d = bus.im_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!bus.stall) begin
               pc_d         = {bus.next_pc[bit_size-1:2], 2'b00};
               retire_cnt_d = retire_cnt_q + CntW'(1);
               if (bus.next_pc[1:0] != 2'b00) begin
                  addr_err_d = 1'b1;
               end
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake and valid are pure state decodes; no input reaches an output.
   assign bus.im_req      = (state_q == S_FETCH);
   assign bus.instr_valid = (state_q == S_EXEC);
   assign bus.im_addr     = pc_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_q + bit_size'(4);
   assign bus.instr       = instr_q;
   assign bus.retire_cnt  = retire_cnt_q;
   assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, hand-written
// reset/stream sequences, and a randomized run against a transaction-level model.
module tb_fetch_pc_unit;

   localparam int unsigned BW = 18;
   localparam int unsigned IW = 32;
   localparam logic [BW-1:0] PC_MASK = '1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   fetch_pc_if #(.bit_size(BW), .instr_width(IW)) bus ();

   fetch_pc_unit #(.bit_size(BW), .instr_width(IW), .reset_pc(18'h00000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          stall;
      logic          ack;
      logic [31:0]   rdata;
      logic [BW-1:0] next_pc;
      logic          exp_req;
      logic          exp_valid;
      logic [BW-1:0] exp_addr;
      logic [BW-1:0] exp_pc4;
      logic [31:0]   exp_instr;
      logic [31:0]   exp_cnt;
      logic          exp_err;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic a, input logic [31:0] d, input logic [BW-1:0] np);
      bus.stall    = s;
      bus.im_ack   = a;
      bus.im_rdata = d;
      bus.next_pc  = np;
   endtask

   // Leaves rst low at posedge+1: the unit is in its single IDLE cycle.
   task automatic do_reset(input bit check_state);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, '0);
      step();
      if (check_state) begin
         chk("rst_req",   32'(bus.im_req), 32'd0);
         chk("rst_valid", 32'(bus.instr_valid), 32'd0);
         chk("rst_pc",    32'(bus.pc), 32'd0);
         chk("rst_instr", bus.instr, 32'd0);
         chk("rst_cnt",   bus.retire_cnt, 32'd0);
         chk("rst_err",   32'(bus.addr_err), 32'd0);
      end
      step();
      rst = 1'b0;
   endtask

   logic [BW-1:0] m_pc;
   logic [31:0]   m_instr;
   logic [31:0]   m_cnt;
   logic          m_err;
   int            m_phase;  // 0: idle cycle, 1: awaiting ack, 2: executing
   logic          r_stall, r_ack;
   logic [31:0]   r_data;
   logic [BW-1:0] r_np;

   initial begin
      drive(1'b0, 1'b0, 32'h0, '0);

      // stall ack rdata next_pc | req valid addr pc4 instr cnt err
      vecs[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 18'h00000, 1'b0, 1'b0, 18'h00000, 18'h00004, 32'h00000000, 32'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h00000000, 18'h00000, 1'b1, 1'b0, 18'h00000, 18'h00004, 32'h00000000, 32'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h00000000, 18'h00000, 1'b1, 1'b0, 18'h00000, 18'h00004, 32'h00000000, 32'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'h8C220004, 18'h00000, 1'b1, 1'b0, 18'h00000, 18'h00004, 32'h00000000, 32'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 32'h55555555, 18'h3FFF0, 1'b0, 1'b1, 18'h00000, 18'h00004, 32'h8C220004, 32'd0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h00000000, 18'h00001, 1'b0, 1'b1, 18'h00000, 18'h00004, 32'h8C220004, 32'd0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'hAAAAAAAA, 18'h00204, 1'b0, 1'b1, 18'h00000, 18'h00004, 32'h8C220004, 32'd0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h00000000, 18'h00000, 1'b0, 1'b1, 18'h00000, 18'h00004, 32'h8C220004, 32'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 18'h00100, 1'b0, 1'b1, 18'h00000, 18'h00004, 32'h8C220004, 32'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h11111111, 18'h00000, 1'b1, 1'b0, 18'h00100, 18'h00104, 32'h8C220004, 32'd1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h00000000, 18'h00102, 1'b0, 1'b1, 18'h00100, 18'h00104, 32'h11111111, 32'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h22222222, 18'h00000, 1'b1, 1'b0, 18'h00100, 18'h00104, 32'h11111111, 32'd2, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h00000000, 18'h3FFFC, 1'b0, 1'b1, 18'h00100, 18'h00104, 32'h22222222, 32'd2, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 32'h33333333, 18'h00000, 1'b1, 1'b0, 18'h3FFFC, 18'h00000, 32'h22222222, 32'd3, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 32'h00000000, 18'h00008, 1'b0, 1'b1, 18'h3FFFC, 18'h00000, 32'h33333333, 32'd3, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 32'h00000000, 18'h00000, 1'b1, 1'b0, 18'h00008, 18'h0000C, 32'h33333333, 32'd4, 1'b1};

      // Directed table: wait states, stall, misaligned retire, PC wrap
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("vec%0d_req", i),   32'(bus.im_req), 32'(vecs[i].exp_req));
         chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_addr", i),  32'(bus.im_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_pc", i),    32'(bus.pc), 32'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_pc4", i),   32'(bus.pc_plus4), 32'(vecs[i].exp_pc4));
         chk($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
         chk($sformatf("vec%0d_cnt", i),   bus.retire_cnt, vecs[i].exp_cnt);
         chk($sformatf("vec%0d_err", i),   32'(bus.addr_err), 32'(vecs[i].exp_err));
         drive(vecs[i].stall, vecs[i].ack, vecs[i].rdata, vecs[i].next_pc);
         step();
      end

      // Zero-wait stream: F/E alternation, addresses 0,4,8,C
      do_reset(1'b0);
      chk("stream_idle_req", 32'(bus.im_req), 32'd0);
      step();
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            chk($sformatf("stream%0d_req", k),  32'(bus.im_req), 32'd1);
            chk($sformatf("stream%0d_addr", k), 32'(bus.im_addr), 32'((k / 2) * 4));
            chk($sformatf("stream%0d_valid", k), 32'(bus.instr_valid), 32'd0);
         end else begin
            chk($sformatf("stream%0d_valid", k), 32'(bus.instr_valid), 32'd1);
            chk($sformatf("stream%0d_req", k),  32'(bus.im_req), 32'd0);
         end
         drive(1'b0, 1'b1, 32'h1000 + 32'(k), BW'((k / 2 + 1) * 4));
         step();
      end
      chk("stream_cnt", bus.retire_cnt, 32'd4);
      chk("stream_addr_end", 32'(bus.im_addr), 32'h10);

      // Reset mid-fetch: req drops immediately, pending and late acks ignored
      drive(1'b0, 1'b0, 32'h0, '0);
      rst = 1'b1;
      #1;
      chk("midrst_req",   32'(bus.im_req), 32'd0);
      chk("midrst_pc",    32'(bus.pc), 32'd0);
      chk("midrst_cnt",   bus.retire_cnt, 32'd0);
      chk("midrst_instr", bus.instr, 32'd0);
      drive(1'b0, 1'b1, 32'hBADC0DE5, '0);
      step();
      rst = 1'b0;
      step();
      drive(1'b0, 1'b0, 32'h0, '0);
      chk("lateack_req",   32'(bus.im_req), 32'd1);
      chk("lateack_valid", 32'(bus.instr_valid), 32'd0);
      chk("lateack_instr", bus.instr, 32'd0);

      // Randomized run against a transaction-level model
      do_reset(1'b0);
      m_pc = '0; m_instr = '0; m_cnt = '0; m_err = 1'b0; m_phase = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_req",   32'(bus.im_req), 32'(m_phase == 1));
         chk("rnd_valid", 32'(bus.instr_valid), 32'(m_phase == 2));
         chk("rnd_addr",  32'(bus.im_addr), 32'(m_pc));
         chk("rnd_pc4",   32'(bus.pc_plus4), 32'((m_pc + 4) & PC_MASK));
         chk("rnd_instr", bus.instr, m_instr);
         chk("rnd_cnt",   bus.retire_cnt, m_cnt);
         chk("rnd_err",   32'(bus.addr_err), 32'(m_err));
         r_stall = ($urandom_range(0, 2) == 0);
         r_ack   = ($urandom_range(0, 2) != 0);
         r_data  = $urandom;
         r_np    = BW'($urandom);
         if ($urandom_range(0, 3) != 0) r_np[1:0] = 2'b00;
         drive(r_stall, r_ack, r_data, r_np);
         if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 1) begin
            if (r_ack) begin
               m_instr = r_data;
               m_phase = 2;
            end
         end else if (!r_stall) begin
            m_pc    = r_np & ~BW'(3);
            m_cnt   = m_cnt + 32'd1;
            m_err   = m_err | (r_np[1:0] != 2'b00);
            m_phase = 1;
         end
         step();
      end

      // Reset from an arbitrary point clears the counter and sticky flag
      rst = 1'b1;
      #1;
      chk("final_rst_cnt",   bus.retire_cnt, 32'd0);
      chk("final_rst_err",   32'(bus.addr_err), 32'd0);
      chk("final_rst_valid", 32'(bus.instr_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
